// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first, WIDTH cycles per result.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             cnext;
  logic [WIDTH-1:0] bload;
  logic             cload;

  always_comb begin
    s     = areg[0] ^ breg[0] ^ c;
    cnext = (areg[0] & breg[0]) | (breg[0] & c) | (areg[0] & c);
  end

  // Subtraction is a + ~b + 1, so only the loaded operand and initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    bload = sub ? ~b : b;
    cload = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    bload = b;
    cload = cin;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            areg  <= a;
            breg  <= bload;
            c     <= cload;
            cnt   <= '0;
            res   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          areg <= {1'b0, areg[WIDTH-1:1]};
          breg <= {1'b0, breg[WIDTH-1:1]};
          c    <= cnext;
          res  <= {s, res[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          // The final bit lands in sum on the same edge it is computed.
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {s, res[WIDTH-1:1]};
            carry <= cnext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): arithmetic model checked every cycle plus literal checks.
// Subtract vectors are compiled in only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  int nvec = 0;
  int nerr = 0;
  bit chk  = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // Model: a result is a+b+cin (or a-b) computed at accept and released WIDTH edges later.
  int             rem = 0;
  logic [WIDTH:0] pending = '0;
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic [WIDTH:0] exp_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rem      = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_res  = '0;
    end else begin
      exp_done = 1'b0;
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_res  = pending;
        end
      end else if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
        if (sub)
          pending = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else
`endif
          pending = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        rem      = WIDTH;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      nvec++;
      if ({busy, done, carry, sum} !== {exp_busy, exp_done, exp_res}) begin
        nerr++;
        $display("[TB] FAIL cycle_model: got busy=%b done=%b carry=%b sum=%h, want busy=%b done=%b carry=%b sum=%h",
                 busy, done, carry, sum, exp_busy, exp_done, exp_res[WIDTH], exp_res[WIDTH-1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Presents one operation for exactly one edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tc, input logic ts);
    tick();
    a     = ta;
    b     = tb;
    cin   = tc;
    sub   = ts;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic countDones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int nd;
    rst_n = 1'b0;
    start = 1'b1;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;

    tick();
    chk = 1'b1;
    tick();
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_done",  32'(done),  32'd0);
    checkOutput("reset_sum",   32'(sum),   32'h00);
    checkOutput("reset_carry", 32'(carry), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] basic add");
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0);
    waitDone(n);
    checkOutput("basic_latency", 32'(n), 32'd9);
    checkOutput("basic_sum",     32'(sum),   32'hE2);
    checkOutput("basic_carry",   32'(carry), 32'd0);

    $display("[TB] carry wrap");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitDone(n);
    checkOutput("wrap_sum",   32'(sum),   32'h00);
    checkOutput("wrap_carry", 32'(carry), 32'd1);
    repeat (5) tick();
    checkOutput("hold_sum",   32'(sum),   32'h00);
    checkOutput("hold_carry", 32'(carry), 32'd1);

    $display("[TB] start during run ignored");
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(n);
    checkOutput("repulse_sum", 32'(sum), 32'h46);
    countDones(12, nd);
    checkOutput("repulse_single_done", 32'(nd), 32'd0);

    $display("[TB] back-to-back");
    tick();
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    a = 8'h40;
    b = 8'h05;
    waitDone(n);
    checkOutput("b2b_first_sum", 32'(sum), 32'h03);
    waitDone(n);
    start = 1'b0;
    checkOutput("b2b_gap",        32'(n),   32'd9);
    checkOutput("b2b_second_sum", 32'(sum), 32'h45);

    $display("[TB] reset mid-run");
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    countDones(12, nd);
    checkOutput("abort_no_done", 32'(nd),    32'd0);
    checkOutput("abort_sum",     32'(sum),   32'h00);
    checkOutput("abort_carry",   32'(carry), 32'd0);
    applyStimulus(8'h02, 8'h03, 1'b0, 1'b0);
    waitDone(n);
    checkOutput("after_abort_sum", 32'(sum), 32'h05);

`ifdef SERIAL_ADDER_SUB_EN
    $display("[TB] subtract");
    applyStimulus(8'h10, 8'h20, 1'b1, 1'b1);
    waitDone(n);
    checkOutput("sub_borrow_sum",   32'(sum),   32'hF0);
    checkOutput("sub_borrow_carry", 32'(carry), 32'd0);
    applyStimulus(8'h20, 8'h10, 1'b0, 1'b1);
    waitDone(n);
    checkOutput("sub_sum",   32'(sum),   32'h10);
    checkOutput("sub_carry", 32'(carry), 32'd1);
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0);
    waitDone(n);
    checkOutput("sub0_basic_sum", 32'(sum), 32'hE2);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitDone(n);
    checkOutput("sub0_wrap_carry", 32'(carry), 32'd1);
`endif

    repeat (3) tick();
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, bit-serial successor to the single-bit full adder. It adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, through a single full-adder cell and a registered carry. A start/busy/done handshake wraps the datapath. It sits in the combinational/arithmetic library as the area-minimal adder for datapaths that can tolerate WIDTH-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while the operation is in RUN.
- done  output  1  one-cycle pulse; sum and carry are valid.
- sum  output  WIDTH  registered result.
- carry  output  1  registered carry-out of bit WIDTH-1.

## Operation
- FSM states:
  - IDLE, reset state: start=1 -> RUN; start=0 -> stay.
  - RUN: bit counter runs 0..WIDTH-1; when the counter reaches WIDTH-1 -> DONE.
  - DONE: lasts exactly one cycle. start=1 -> RUN (back-to-back accept); start=0 -> IDLE.
- On accept:
  - a and b load into shift registers.
  - cin loads into the carry flop.
  - The bit counter clears to 0.
- Each RUN cycle:
  - s = a[0]^b[0]^c
  - c_next = a[0]&b[0] | b[0]&c | a[0]&c
  - s shifts into the result register from the MSB side.
  - The a and b registers shift right by one.
  - The counter increments.
- Entering DONE: sum <= result register and carry <= carry flop, on the same edge.
- sum and carry hold their value until the next completion.
- start while in RUN is ignored; it is neither queued nor does it disturb the operation.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic: {carry, sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- Bit counter width is $clog2(WIDTH).

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, carry=0.
  - Internal shift registers, carry flop and counter clear to 0.
- Reset mid-RUN aborts the operation. No done is produced, and sum/carry clear to 0.
- Latency: start accepted at edge k.
  - busy=1 for the cycles following edges k .. k+WIDTH-1.
  - After edge k+WIDTH: done=1 and busy=0, with the new sum/carry visible in the same cycle.
- Throughput: with start held high, one result every WIDTH+1 cycles.
- busy and done are never high together.
- done is high for exactly one cycle per accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - If sub=1 on accept: b latches as ~b, the carry flop loads 1, and cin is ignored.
  - Result is a - b; carry=1 means no borrow (a >= b unsigned).
  - sub=0 behaves exactly as the add-only build.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port and no inversion logic.
  - Add only, behaviour as described above.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=8'h00, carry=0; state remains IDLE after release if start=0.
- Basic add, WIDTH=8: a=8'hA5, b=8'h3C, cin=1, start pulse at edge k -> busy for 8 cycles, done at k+8, sum=8'hE2, carry=0.
- Carry-out wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1; sum/carry hold until the next done.
- Handshake:
  - start re-pulsed at RUN cycle 3 -> ignored; a single done, with the original result.
  - start held high through DONE -> next op accepted, done again 9 cycles later.
- Reset mid-operation: rst_n=0 during RUN bit 4 of a=8'h0F+b=8'h01 -> no done; sum=0, carry=0; next op a=8'h02+b=8'h03 -> sum=8'h05.
- SERIAL_ADDER_SUB_EN:
  - sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, carry=0.
  - sub=1, a=8'h20, b=8'h10 -> sum=8'h10, carry=1.
  - Re-run all of the above with sub=0 -> unchanged results.
